// File: rtl/cmd_fifo_param.sv
// Parametrised command FIFO with status flags, fill level, sticky overflow, flush and full-policy.
// Optional saturating overflow counter on port ovf_count when CMD_FIFO_OVF_CNT_EN is defined.
module cmd_fifo_param #(
  parameter int unsigned DATA_W      = 4,
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned AFULL_LVL   = DEPTH - 2,
  parameter bit          DROP_OLDEST = 1'b0
) (
  input  logic                     sys_clock,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop_en,
  input  logic                     flush,
  input  logic                     clear_ovf,
  output logic [DATA_W-1:0]        pop_data,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level,
`ifdef CMD_FIFO_OVF_CNT_EN
  output logic [7:0]               ovf_count,
`endif
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]     lvl_q, lvl_d;
  logic              ovf_q, ovf_d;
  logic              is_full, pop_eff, wr_en, ovf_evt;

  always_comb begin
    is_full = (lvl_q == LW'(DEPTH));
    pop_eff = pop_en && (lvl_q != '0);
    wr_en   = !flush && push_valid && (!is_full || pop_eff || DROP_OLDEST);
    ovf_evt = !flush && push_valid && is_full && !pop_eff;
    wr_d    = wr_q;
    rd_d    = rd_q;
    lvl_d   = lvl_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      lvl_d = '0;
    end else begin
      if (wr_en) wr_d = wr_q + 1'b1;
      // A write into a full FIFO without a pop overwrites the oldest entry, so the head moves too.
      if (pop_eff || (wr_en && is_full)) rd_d = rd_q + 1'b1;
      if (wr_en && !pop_eff && !is_full) lvl_d = lvl_q + 1'b1;
      else if (pop_eff && !wr_en)        lvl_d = lvl_q - 1'b1;
    end
    ovf_d = ovf_evt | (ovf_q & ~clear_ovf);
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge sys_clock) begin
    if (wr_en) mem_q[wr_q] <= push_data;
  end

`ifdef CMD_FIFO_OVF_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_ovf)                     cnt_d = '0;
    else if (ovf_evt && cnt_q != '1)   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ovf_count = cnt_q;
`endif

  assign empty       = (lvl_q == '0);
  assign full        = is_full;
  assign almost_full = (lvl_q >= LW'(AFULL_LVL));
  assign level       = lvl_q;
  assign overflow    = ovf_q;
  assign pop_data    = empty ? '0 : mem_q[rd_q];

endmodule
